// File: rtl/arr_wr_arbiter_pkg.sv
// Shared defaults and array types for the round-robin write arbiter.
package arr_arb_pkg;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [WIDTH-1:0]          data_t;
  typedef logic [$clog2(DEPTH)-1:0]  addr_t;
  typedef data_t                     arr_t [DEPTH-1:0];
  typedef logic [DEPTH-1:0][WIDTH-1:0] arr_packed_t;

endpackage

// File: rtl/arr_wr_arbiter_if.sv
// Valid/ready write request bundle from NREQ requesters to the arbiter.
interface arr_wr_if #(
  parameter int NREQ  = arr_arb_pkg::NREQ,
  parameter int DEPTH = arr_arb_pkg::DEPTH,
  parameter int WIDTH = arr_arb_pkg::WIDTH
);
  import arr_arb_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [NREQ-1:0]  req_valid;
  logic [AW-1:0]    req_addr [NREQ-1:0];
  logic [WIDTH-1:0] req_data [NREQ-1:0];
  logic [NREQ-1:0]  req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/arr_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = arr_arb_pkg::NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);
  import arr_arb_pkg::*;

  localparam int IW = $clog2(NREQ);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arr_wr_arbiter.sv
// Shared DEPTH x WIDTH register array written by NREQ requesters under
// round-robin arbitration; contents exposed both unpacked and packed.
module arr_wr_arbiter #(
  parameter int NREQ  = arr_arb_pkg::NREQ,
  parameter int DEPTH = arr_arb_pkg::DEPTH,
  parameter int WIDTH = arr_arb_pkg::WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  arr_wr_if.slave                     bus,
  output logic [WIDTH-1:0]            arr_q [DEPTH-1:0],
  output logic [DEPTH-1:0][WIDTH-1:0] arr_packed,
  output logic [$clog2(NREQ)-1:0]     last_gnt,
  output logic [7:0]                  wr_cnt
);
  import arr_arb_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    last_gnt_q, last_gnt_d;
  logic [7:0]       wr_cnt_q, wr_cnt_d;
  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic             commit;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] mem_q [DEPTH-1:0];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are masked while reset is asserted so nothing is accepted mid-reset.
  assign bus.req_ready = rst_n ? gnt : '0;
  assign commit        = |(bus.req_valid & bus.req_ready);
  assign wr_addr       = bus.req_addr[gnt_idx];
  assign wr_data       = bus.req_data[gnt_idx];

  always_comb begin
    ptr_d      = ptr_q;
    last_gnt_d = last_gnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (commit) begin
      ptr_d      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      last_gnt_d = gnt_idx;
      if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      last_gnt_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      last_gnt_q <= last_gnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else if (commit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign arr_q = mem_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign arr_packed[g] = mem_q[g];
  end

  assign last_gnt = last_gnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_arr_wr_arbiter.sv
// Self-checking bench for arr_wr_arbiter against a round-robin reference model.
module tb_arr_wr_arbiter;
  import arr_arb_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  arr_t        arr_q;
  arr_packed_t arr_packed;
  logic [IW-1:0] last_gnt;
  logic [7:0]  wr_cnt;

  int checks = 0;
  int errors = 0;

  int m_arr [DEPTH];
  int m_ptr, m_last, m_cnt;

  arr_wr_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  arr_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .arr_q      (arr_q),
    .arr_packed (arr_packed),
    .last_gnt   (last_gnt),
    .wr_cnt     (wr_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: priority scan from ptr with modular arithmetic.
  function automatic int m_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_onehot(input int i);
    logic [NREQ-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] m_packed();
    logic [DEPTH*WIDTH-1:0] p;
    p = '0;
    for (int d = 0; d < DEPTH; d++) p[d*WIDTH +: WIDTH] = WIDTH'(m_arr[d]);
    return p;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < DEPTH; d++) m_arr[d] = 0;
    m_ptr = 0; m_last = 0; m_cnt = 0;
  endtask

  task automatic m_commit();
    int g;
    g = m_pick(bus.req_valid);
    if (g >= 0) begin
      m_arr[int'(bus.req_addr[g])] = int'(bus.req_data[g]);
      m_ptr  = (g + 1) % NREQ;
      m_last = g;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic drive_rand(input logic [NREQ-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = AW'($urandom_range(0, DEPTH - 1));
      bus.req_data[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_rand('0);
    #2;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    drive_rand('1);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    for (int d = 0; d < DEPTH; d++) begin
      checks++;
      if (arr_q[d] !== '0) begin
        errors++; $display("FAIL reset_arr[%0d]: got %h want 0", d, arr_q[d]);
      end
    end
    checks++;
    if (arr_packed !== 16'h0000) begin
      errors++; $display("FAIL reset_packed: got %h want 0000", arr_packed);
    end
    checks++;
    if (wr_cnt !== 8'd0 || last_gnt !== 2'd0) begin
      errors++; $display("FAIL reset_regs: got cnt %0d last %0d want 0 0", wr_cnt, last_gnt);
    end
    @(negedge clk);
    drive_rand('0);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    drive_rand(4'b0100);
    bus.req_addr[2] = 2'd1;
    bus.req_data[2] = 4'b1010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b want 0100", bus.req_ready);
    end
    m_commit();
    @(posedge clk); #1;
    checks++;
    if (arr_q[1] !== 4'b1010 || arr_packed !== 16'h00A0) begin
      errors++; $display("FAIL single_arr: got arr1 %h packed %h want a 00a0", arr_q[1], arr_packed);
    end
    checks++;
    if (last_gnt !== 2'd2 || wr_cnt !== 8'd1) begin
      errors++; $display("FAIL single_regs: got last %0d cnt %0d want 2 1", last_gnt, wr_cnt);
    end
  endtask

  task automatic test_full_contention();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[i] = AW'(i);
        bus.req_data[i] = WIDTH'(i + 1);
      end
      #1;
      checks++;
      if (bus.req_ready !== m_onehot(c % NREQ)) begin
        errors++; $display("FAIL contention_ready c%0d: got %b want %b", c, bus.req_ready, m_onehot(c % NREQ));
      end
      m_commit();
      @(posedge clk); #1;
      checks++;
      if (last_gnt !== IW'(c % NREQ)) begin
        errors++; $display("FAIL contention_last c%0d: got %0d want %0d", c, last_gnt, c % NREQ);
      end
    end
    checks++;
    if (arr_packed !== 16'h4321 || wr_cnt !== 8'd5) begin
      errors++; $display("FAIL contention_final: got packed %h cnt %0d want 4321 5", arr_packed, wr_cnt);
    end
  endtask

  task automatic test_wrap_priority();
    logic [NREQ-1:0] v  [3] = '{4'b0010, 4'b1010, 4'b1010};
    logic [NREQ-1:0] er [3] = '{4'b0010, 4'b1000, 4'b0010};
    int              el [3] = '{1, 3, 1};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_rand(v[c]);
      #1;
      checks++;
      if (bus.req_ready !== er[c]) begin
        errors++; $display("FAIL wrap_ready c%0d: got %b want %b", c, bus.req_ready, er[c]);
      end
      m_commit();
      @(posedge clk); #1;
      checks++;
      if (last_gnt !== IW'(el[c])) begin
        errors++; $display("FAIL wrap_last c%0d: got %0d want %0d", c, last_gnt, el[c]);
      end
    end
  endtask

  task automatic test_collision();
    logic [NREQ-1:0] v  [2] = '{4'b0011, 4'b0010};
    logic [NREQ-1:0] er [2] = '{4'b0001, 4'b0010};
    logic [WIDTH-1:0] ed [2] = '{4'd5, 4'd9};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_rand(v[c]);
      bus.req_addr[0] = 2'd3; bus.req_data[0] = 4'd5;
      bus.req_addr[1] = 2'd3; bus.req_data[1] = 4'd9;
      #1;
      checks++;
      if (bus.req_ready !== er[c]) begin
        errors++; $display("FAIL collide_ready c%0d: got %b want %b", c, bus.req_ready, er[c]);
      end
      m_commit();
      @(posedge clk); #1;
      checks++;
      if (arr_q[3] !== ed[c]) begin
        errors++; $display("FAIL collide_arr3 c%0d: got %0d want %0d", c, arr_q[3], ed[c]);
      end
    end
  endtask

  task automatic test_random(input int n, input bit allow_idle);
    logic [NREQ-1:0] v;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      v = allow_idle ? NREQ'($urandom_range(0, (1 << NREQ) - 1))
                     : NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drive_rand(v);
      #1;
      checks++;
      if (bus.req_ready !== m_onehot(m_pick(v))) begin
        errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, m_onehot(m_pick(v)));
      end
      m_commit();
      @(posedge clk); #1;
      checks++;
      if (arr_packed !== m_packed()) begin
        errors++; $display("FAIL rand_packed c%0d: got %h want %h", c, arr_packed, m_packed());
      end
      for (int d = 0; d < DEPTH; d++) begin
        checks++;
        if (arr_q[d] !== WIDTH'(m_arr[d])) begin
          errors++; $display("FAIL rand_arr[%0d] c%0d: got %h want %h", d, c, arr_q[d], m_arr[d]);
        end
      end
      checks++;
      if (wr_cnt !== 8'(m_cnt) || last_gnt !== IW'(m_last)) begin
        errors++; $display("FAIL rand_regs c%0d: got cnt %0d last %0d want %0d %0d", c, wr_cnt, last_gnt, m_cnt, m_last);
      end
    end
  endtask

  task automatic test_saturation();
    test_random(300, 1'b0);
    checks++;
    if (wr_cnt !== 8'd255) begin
      errors++; $display("FAIL saturation: got %0d want 255", wr_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    drive_rand(4'b1111);
    m_commit();
    @(posedge clk);
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || arr_packed !== 16'h0000) begin
      errors++; $display("FAIL midrst_clear: got ready %b packed %h want 0000 0000", bus.req_ready, arr_packed);
    end
    checks++;
    if (wr_cnt !== 8'd0 || last_gnt !== 2'd0) begin
      errors++; $display("FAIL midrst_regs: got cnt %0d last %0d want 0 0", wr_cnt, last_gnt);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_rand(4'b1111);
      if (c == 0) #2 rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== m_onehot(c)) begin
        errors++; $display("FAIL midrst_restart c%0d: got %b want %b", c, bus.req_ready, m_onehot(c));
      end
      m_commit();
      @(posedge clk); #1;
      checks++;
      if (wr_cnt !== 8'(c + 1) || last_gnt !== IW'(c) || arr_packed !== m_packed()) begin
        errors++; $display("FAIL midrst_after c%0d: got cnt %0d last %0d packed %h want %0d %0d %h",
                           c, wr_cnt, last_gnt, arr_packed, c + 1, c, m_packed());
      end
    end
  endtask

  initial begin
    drive_rand('0);
    m_reset();
    test_reset();
    test_single_write();
    test_full_contention();
    test_wrap_priority();
    test_collision();
    test_saturation();
    test_reset_midstream();
    test_random(150, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arr_wr_arbiter.md
# arr_wr_arbiter

Round-robin write arbiter that shares one DEPTH×WIDTH register array among NREQ requesters using a valid/ready handshake. It owns the storage (`logic [WIDTH-1:0] arr [DEPTH-1:0]`) and grants at most one write per cycle. It exposes the contents both as an unpacked array and as a packed `[DEPTH-1:0][WIDTH-1:0]` vector, so downstream blocks of either array style connect directly.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `DEPTH`, 4, array entries (power of 2)
- `WIDTH`, 4, bits per entry
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  [NREQ-1:0]  per-requester write request
- `req_addr`  in  unpacked [NREQ-1:0] of [$clog2(DEPTH)-1:0]  target entry per requester
- `req_data`  in  unpacked [NREQ-1:0] of [WIDTH-1:0]  write data per requester
- `req_ready`  out  [NREQ-1:0]  one-hot grant, combinational
- `arr_q`  out  unpacked [DEPTH-1:0] of [WIDTH-1:0]  array contents
- `arr_packed`  out  [DEPTH-1:0][WIDTH-1:0]  same contents, packed; `arr_packed[i] == arr_q[i]` always
- `last_gnt`  out  [$clog2(NREQ)-1:0]  index of most recent granted requester
- `wr_cnt`  out  8  committed-write count, saturating

## Operation
- Round-robin pointer `ptr` (range 0..NREQ-1) marks the highest-priority requester. Priority order is ptr, ptr+1, …, wrapping modulo NREQ.
- `req_ready[i]` = 1 iff `req_valid[i]` and i is the first valid requester in that order. At most one bit is set. All bits are 0 when no requester is valid.
- A write commits when `req_valid[i] & req_ready[i]`: `arr[req_addr[i]] <= req_data[i]`.
- On commit:
  - `ptr <= (i+1) mod NREQ`
  - `last_gnt <= i`
  - `wr_cnt <= min(wr_cnt+1, 255)`
- With no commit, `ptr`, `last_gnt`, `wr_cnt` and `arr` hold their values.
- A requester keeps `valid`, `addr` and `data` stable until granted. A requester that drops `valid` before its grant simply loses its turn; this is not an error.
- Back-to-back writes to the same address: last commit wins.
- Requester i waits at most NREQ-1 cycles while continuously valid. No starvation.
- Reset (rst_n low, at any time, including mid-stream) immediately clears:
  - every `arr` entry to 0
  - `ptr` to 0
  - `last_gnt` to 0
  - `wr_cnt` to 0
  - `req_ready` to all 0, forced low while rst_n is low

## Timing
- Grant: zero latency. `req_ready` depends combinationally on `req_valid` and the registered `ptr` only, never on `req_addr` or `req_data`.
- Write: the entry is visible on `arr_q` / `arr_packed` in the cycle after commit (1-cycle latency).
- `ptr`, `last_gnt` and `wr_cnt` update at the same edge as the array write.
- Throughput: one write per cycle. Full-rate round-robin when all requesters are valid.
- Reset deassertion: the first grant is possible in the first cycle after rst_n rises.

## Structure
- Package `arr_arb_pkg` holds:
  - default parameters NREQ, DEPTH, WIDTH
  - `typedef logic [WIDTH-1:0] data_t`
  - `typedef logic [$clog2(DEPTH)-1:0] addr_t`
  - `typedef data_t arr_t [DEPTH-1:0]`
  - `typedef logic [DEPTH-1:0][WIDTH-1:0] arr_packed_t`
- Sub-module `rr_arbiter` (parameter NREQ): takes `req` and `ptr`, returns one-hot `gnt` and encoded `gnt_idx`. It is purely combinational.
- Top level `arr_wr_arbiter` contains the `ptr`/`last_gnt`/`wr_cnt` registers, the storage array and the packed/unpacked output mapping.

## Test plan
- Reset: hold rst_n=0 with all `req_valid`=1 → `req_ready`=0000, every `arr_q` entry 0, `arr_packed`=16'h0000, `wr_cnt`=0.
- Single write: after reset, `req_valid`=0100, `req_addr[2]`=1, `req_data[2]`=4'b1010 → `req_ready`=0100 in the same cycle. Next cycle: `arr_q[1]`=1010, `arr_packed`=16'h00A0, `last_gnt`=2, `wr_cnt`=1.
- Full contention: `req_valid`=1111 held for 5 cycles from ptr=0, requester i writes addr i, data i+1 → grant order 0,1,2,3,0. Final `arr_packed`=16'h4321, `wr_cnt`=5.
- Wrap priority: ptr=2, `req_valid`=1010 → requester 3 granted first, then requester 1. `last_gnt` goes 3 then 1.
- Same-address collision and saturation: requesters 0 and 1 both write addr 3 with data 5 and data 9 → `arr_q[3]`=9 after both commits. Continue to 300 total writes → `wr_cnt` stays at 255.
- Reset mid-stream: pull rst_n low asynchronously during full contention → outputs clear before the next clk edge. After release, arbitration restarts at requester 0.
